// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-writable dual-port RAM family.
package ram_pkg;

    // Controller modes: normal access or hardware array clear.
    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } ram_state_t;

    // Number of byte lanes in a data word.
    function automatic int unsigned num_lanes(input int unsigned data_w, input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/ram_core_1w1r.sv
// Bare 1-write/1-read storage array with per-lane write enables and a
// registered, read-before-write read port. No reset so it maps onto block RAM.
module ram_core_1w1r
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          rdata
);

    localparam int unsigned LANES = num_lanes(DATA_W, BYTE_W);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Lane-gated write and old-data read; the top merges forwarded lanes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we && be[i]) begin
                mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_dp_bytewr.sv
// Simple dual-port RAM with byte-lane writes, write-first forwarding and a
// hardware clear sequencer that zeroes the array after reset or on request.
module ram_dp_bytewr
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_start,
    output logic                       busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          din,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid
);

    localparam int unsigned LANES = num_lanes(DATA_W, BYTE_W);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    ram_state_t          state, state_d;
    logic [ADDR_W-1:0]   cnt, cnt_d;
    logic                busy_d;
    logic                dout_valid_d;

    // Forwarded lanes for the last accepted read; reset to all-forwarded
    // zero data so dout reads 0 without resetting the array's read register.
    logic [LANES-1:0]    fwd_mask, fwd_mask_d;
    logic [DATA_W-1:0]   fwd_data, fwd_data_d;

    logic                core_we;
    logic [ADDR_W-1:0]   core_waddr;
    logic [DATA_W-1:0]   core_wdata;
    logic [LANES-1:0]    core_be;
    logic                core_re;
    logic [DATA_W-1:0]   core_rdata;

    // State, clear counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            busy       <= 1'b1;
            dout_valid <= 1'b0;
            fwd_mask   <= '1;
            fwd_data   <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            busy       <= busy_d;
            dout_valid <= dout_valid_d;
            fwd_mask   <= fwd_mask_d;
            fwd_data   <= fwd_data_d;
        end
    end

    // Next-state logic and array port steering (clear sweep or user access).
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        busy_d       = busy;
        dout_valid_d = 1'b0;
        fwd_mask_d   = fwd_mask;
        fwd_data_d   = fwd_data;
        core_we      = 1'b0;
        core_waddr   = waddr;
        core_wdata   = din;
        core_be      = be;
        core_re      = 1'b0;

        unique case (state)
            ST_CLEAR: begin
                core_we    = 1'b1;
                core_waddr = cnt;
                core_wdata = '0;
                core_be    = '1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                core_we      = we;
                core_re      = re;
                dout_valid_d = re;
                if (re) begin
                    fwd_mask_d = (we && (waddr == raddr)) ? be : '0;
                    fwd_data_d = din;
                end
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    ram_core_1w1r #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .be    (core_be),
        .re    (core_re),
        .raddr (raddr),
        .rdata (core_rdata)
    );

    // Write-first merge: forwarded lanes override the old array contents.
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        assign dout[i*BYTE_W +: BYTE_W] = fwd_mask[i] ? fwd_data[i*BYTE_W +: BYTE_W]
                                                      : core_rdata[i*BYTE_W +: BYTE_W];
    end

endmodule

// File: tb/tb_ram_dp_bytewr.sv
// Directed bench for ram_dp_bytewr with a cycle-level behavioural model.
module tb_ram_dp_bytewr;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_start;
    logic        busy;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] din;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  raddr;
    logic [15:0] dout;
    logic        dout_valid;

    int n_vec = 0;
    int n_err = 0;

    ram_dp_bytewr #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_start  (clr_start),
        .busy       (busy),
        .we         (we),
        .waddr      (waddr),
        .din        (din),
        .be         (be),
        .re         (re),
        .raddr      (raddr),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: memory array plus remaining clear cycles.
    logic [15:0] mdl [DEPTH];
    int          clr_left = DEPTH;
    logic [15:0] exp_dout = 16'h0;
    logic        exp_valid = 1'b0;
    logic        exp_busy = 1'b1;
    logic [15:0] mdl_rd;

    always @(posedge clk) begin
        if (rst) begin
            exp_busy  = 1'b1;
            exp_dout  = 16'h0;
            exp_valid = 1'b0;
            clr_left  = DEPTH;
            for (int a = 0; a < DEPTH; a++) mdl[a] = 16'h0;
        end else if (clr_left > 0) begin
            clr_left--;
            exp_valid = 1'b0;
            exp_busy  = (clr_left > 0);
        end else begin
            exp_valid = re;
            if (re) begin
                mdl_rd = mdl[raddr];
                if (we && waddr == raddr) begin
                    if (be[0]) mdl_rd[7:0]  = din[7:0];
                    if (be[1]) mdl_rd[15:8] = din[15:8];
                end
                exp_dout = mdl_rd;
            end
            if (we) begin
                if (be[0]) mdl[waddr][7:0]  = din[7:0];
                if (be[1]) mdl[waddr][15:8] = din[15:8];
            end
            if (clr_start) begin
                clr_left = DEPTH;
                exp_busy = 1'b1;
                for (int a = 0; a < DEPTH; a++) mdl[a] = 16'h0;
            end
        end
        #1;
        check("model_busy", 32'(busy), 32'(exp_busy));
        check("model_dout", 32'(dout), 32'(exp_dout));
        check("model_valid", 32'(dout_valid), 32'(exp_valid));
    end

    task automatic step(input logic w, input logic [3:0] wa, input logic [15:0] d,
                        input logic [1:0] b, input logic r, input logic [3:0] ra,
                        input logic c);
        @(negedge clk);
        we = w; waddr = wa; din = d; be = b; re = r; raddr = ra; clr_start = c;
    endtask

    task automatic step_idle();
        step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        step(1'b1, a, d, b, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [15:0] exp);
        step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, a, 1'b0);
        after_edge();
        check(name, 32'(dout), 32'(exp));
        check({name, "_valid"}, 32'(dout_valid), 32'(1));
    endtask

    // Counts busy cycles starting at the current negedge, bounded.
    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step_idle();
        end
    endtask

    int ncyc;

    initial begin
        we = 0; waddr = 0; din = 0; be = 0; re = 0; raddr = 0; clr_start = 0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_valid", 32'(dout_valid), 32'(0));

        // 1: power-up clear then all-zero reads back to back
        rst = 1'b0;
        wait_clear(ncyc);
        check("clear_len_reset", 32'(ncyc), 32'(16));
        for (int a = 0; a < DEPTH; a++) read_check("zero_rd", 4'(a), 16'h0000);
        step_idle();
        after_edge();
        check("valid_drop", 32'(dout_valid), 32'(0));

        // 2: full-word writes and reads
        write(4'd2, 16'hAAAA, 2'b11);
        write(4'd4, 16'h5555, 2'b11);
        read_check("rd_a2", 4'd2, 16'hAAAA);
        read_check("rd_a4", 4'd4, 16'h5555);

        // 3: upper-lane partial write
        write(4'd7, 16'h1234, 2'b11);
        write(4'd7, 16'hABCD, 2'b10);
        read_check("rd_partial", 4'd7, 16'hAB34);

        // 4: same-address write-first with lower lane only
        write(4'd3, 16'h00FF, 2'b11);
        step(1'b1, 4'd3, 16'hC3C3, 2'b01, 1'b1, 4'd3, 1'b0);
        after_edge();
        check("wf_dout", 32'(dout), 32'(16'h00C3));
        check("wf_valid", 32'(dout_valid), 32'(1));

        // different addresses in one cycle, and be=0 no-op
        step(1'b1, 4'd9, 16'h9999, 2'b11, 1'b1, 4'd2, 1'b0);
        after_edge();
        check("diff_addr", 32'(dout), 32'(16'hAAAA));
        write(4'd9, 16'h1111, 2'b00);
        read_check("be_zero", 4'd9, 16'h9999);

        // 5: fill, clear with concurrent write, accesses during busy ignored
        for (int a = 0; a < DEPTH; a++) write(4'(a), 16'(16'h0101 * (a + 1)), 2'b11);
        read_check("fill_a5", 4'd5, 16'h0606);
        step(1'b1, 4'd5, 16'h5A5A, 2'b11, 1'b0, 4'h0, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, 4'd5, 16'hFFFF, 2'b11, 1'b1, 4'(k), 1'b0);
            check("busy_during_clr", 32'(busy), 32'(1));
        end
        step_idle();
        check("busy_end_clr", 32'(busy), 32'(0));
        for (int a = 0; a < DEPTH; a++) read_check("post_clr", 4'(a), 16'h0000);

        // 6: reset in the middle of a clear
        write(4'd1, 16'hBEEF, 2'b11);
        read_check("rd_beef", 4'd1, 16'hBEEF);
        step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'h0, 1'b1);
        repeat (8) step_idle();
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'(1));
        check("midrst_dout", 32'(dout), 32'(0));
        check("midrst_valid", 32'(dout_valid), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_clear(ncyc);
        check("clear_len_midrst", 32'(ncyc), 32'(16));
        read_check("after_midrst", 4'd1, 16'h0000);

        step_idle();
        after_edge();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_dp_bytewr.md
# ram_dp_bytewr

Parametrised simple-dual-port synchronous RAM, the next generation of the team's 16x8 `sync_ram`. It adds:
- independent write and read ports in one cycle
- generic width and depth
- per-byte write enables with write-first forwarding
- a hardware clear sequencer that zeroes the array after reset and on request

It is the storage primitive for buffers and register files in the design.

## Interface
Parameters:
- `DATA_W`, default 16: data width in bits. Must be a multiple of `BYTE_W`.
- `BYTE_W`, default 8: width of one byte lane.
- `ADDR_W`, default 4: address width. `DEPTH = 2**ADDR_W` entries.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr_start`  in  1  request a full-array clear; sampled in IDLE only.
- `busy`  out  1  high while the clear sequence runs; accesses are ignored.
- `we`  in  1  write enable.
- `waddr`  in  `ADDR_W`  write address.
- `din`  in  `DATA_W`  write data.
- `be`  in  `DATA_W/BYTE_W`  byte-lane write enables; bit i gates `din[i*BYTE_W +: BYTE_W]`.
- `re`  in  1  read enable.
- `raddr`  in  `ADDR_W`  read address.
- `dout`  out  `DATA_W`  registered read data.
- `dout_valid`  out  1  one-cycle strobe marking new `dout`.

## Operation
- FSM states: `ST_CLEAR`, `ST_IDLE`.
- Reset state is `ST_CLEAR` with clear counter = 0.
- `ST_CLEAR`:
  - each cycle, write 0 to `mem[cnt]`, then `cnt++`.
  - when `cnt == DEPTH-1` is written, go to `ST_IDLE`.
  - `we`, `re` and `clr_start` are ignored; `dout_valid` = 0.
- `ST_IDLE`, `clr_start`=1: go to `ST_CLEAR` with cnt=0. Any `we`/`re` in that same cycle is still executed normally.
- Write (`ST_IDLE`, `we`=1): each lane i with `be[i]`=1 updates `mem[waddr]` lane i. Lanes with `be[i]`=0 are untouched. `we`=1 with `be`=0 is a no-op.
- Read (`ST_IDLE`, `re`=1): `dout <= mem[raddr]` and `dout_valid <= 1`.
- `re`=0 or busy: `dout` holds its last value; `dout_valid <= 0`.
- Same-cycle write and read to the same address is write-first. `dout` returns, per lane:
  - `din` where `be[i]`=1;
  - the old memory contents otherwise.
- Different addresses: both accesses complete independently.
- Addresses wrap naturally; there is no out-of-range case.

## Timing
- Reset values: `busy`=1, `dout`=0, `dout_valid`=0, state=`ST_CLEAR`, cnt=0. The memory array itself is not reset; the clear sequence zeroes it.
- Clear duration: exactly `DEPTH` cycles of `busy`=1, counted from reset release, or from the cycle after `clr_start` is sampled.
- First access is accepted on the first edge with `busy`=0.
- Read latency: 1 cycle. Data for `re` sampled at edge N appears on `dout` after edge N, with `dout_valid`=1 for that cycle only.
- Write latency: stored at edge N; a read of that address sampled at edge N+1 returns the new data.
- `busy` is registered. Software must check `busy` before issuing `we`/`re`.
- `rst` asserted mid-operation (mid-clear or mid-read):
  - outputs return immediately to their reset values;
  - the clear restarts from address 0 after release.
- Back-to-back reads every cycle give `dout_valid` continuously high.

## Structure
- Shared package `ram_pkg`:
  - `ram_state_t` enum {`ST_IDLE`, `ST_CLEAR`};
  - function `num_lanes(DATA_W, BYTE_W)`.
- Sub-module `ram_core_1w1r`:
  - bare storage array with per-lane write enable and registered read;
  - no reset; inferable as block RAM.
- The top level holds the FSM, clear counter, write-first bypass mux, and the `busy`/`dout_valid` registers.

## Test plan
All scenarios use `DATA_W`=16, `BYTE_W`=8, `ADDR_W`=4.

1. Release `rst` → `busy`=1 for exactly 16 cycles. Then reads of addresses 0..15 each return 16'h0000 with `dout_valid` pulsing.
2. Write addr 2 = 16'hAAAA with `be`=2'b11, and addr 4 = 16'h5555 with `be`=2'b11. Read addr 2 then addr 4 → `dout` is 16'hAAAA then 16'h5555, each one cycle after its `re`.
3. Addr 7 holds 16'h1234. Write `din`=16'hABCD, `be`=2'b10, then read addr 7 → 16'hAB34.
4. Addr 3 holds 16'h00FF. In the same cycle issue `we` (addr 3, `din`=16'hC3C3, `be`=2'b01) and `re` (addr 3) → next cycle `dout`=16'h00C3, `dout_valid`=1.
5. Fill all addresses with nonzero data, then pulse `clr_start` together with a write to addr 5. Expected:
   - `busy` high for 16 cycles;
   - `we`/`re` during `busy` produce no `dout_valid` and no memory change;
   - afterwards, all reads return 0.
6. Assert `rst` at clear cycle 8 → `busy` stays 1, `dout`=0, `dout_valid`=0. After release, `busy` lasts a full 16 cycles.
